imem_boot_arbiter: RTL and testbench

Owns the single port of the synchronous instruction memory and shares it between the boot loader (program download) and the core's fetch stage. Sequences the core's life cycle: hold in reset, download program words, release the core for fetch, re-enter download on request. Sits between the loader interface, the fetch stage and the instruction memory macro (1-cycle registered read).

---
 rtl/imem_boot_arbiter.sv | 103 ++++++++++
 tb/tb_imem_boot_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_arbiter.sv
// Shares the single instruction-memory port between the boot loader and fetch, and sequences core hold/download/run.
// Latency: loader writes and fetch grants issue in the same cycle; fetch data returns 1 cycle after grant; ld_ready/fetch_gnt give backpressure.
module imem_boot_arbiter #(
  parameter int unsigned          ADDR_W   = 10,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              core_hold,
  output logic              fetch_err,
  output logic [ADDR_W:0]   ld_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_t state;
  logic   rd_pend;
  logic   rd_nop;
  logic   ld_fire;
  logic   fetch_bad;
  logic   fetch_mem;

  assign ld_ready  = (state == LOAD);
  assign ld_fire   = ld_ready & ld_valid;
  assign core_hold = (state != RUN);

  // boot_start takes priority over a fetch so no new read is launched while leaving RUN
  assign fetch_gnt = (state == RUN) & fetch_req & ~boot_start;
  assign fetch_bad = (fetch_addr[1:0] != '0) || (fetch_addr[31:ADDR_W+2] != '0);
  assign fetch_mem = fetch_gnt & ~fetch_bad;

  assign mem_en    = ld_fire | fetch_mem;
  assign mem_we    = ld_fire;
  assign mem_addr  = ld_fire ? ld_addr : (fetch_mem ? fetch_addr[ADDR_W+1:2] : '0);
  assign mem_wdata = ld_fire ? ld_data : '0;

  // Read data comes straight from the macro's output register in the cycle after the grant
  assign fetch_valid = rd_pend;
  assign fetch_data  = !rd_pend ? '0 : (rd_nop ? NOP_WORD : mem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      rd_nop    <= 1'b0;
      fetch_err <= 1'b0;
      ld_count  <= '0;
    end else begin
      rd_pend <= fetch_gnt;
      rd_nop  <= fetch_gnt & fetch_bad;
      if (fetch_gnt && fetch_bad)
        fetch_err <= 1'b1;

      case (state)
        IDLE: begin
          if (boot_start) begin
            state     <= LOAD;
            ld_count  <= '0;
            fetch_err <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            ld_count <= ld_count + 1'b1;
            if (ld_last || ld_count == LAST_CNT)
              state <= RUN;
          end
        end
        DRAIN: begin
          state <= LOAD;
        end
        RUN: begin
          if (boot_start) begin
            state     <= rd_pend ? DRAIN : LOAD;
            ld_count  <= '0;
            fetch_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a 1-cycle registered-read memory model.
module tb_imem_boot_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst;
  logic              boot_start;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              core_hold;
  logic              fetch_err;
  logic [ADDR_W:0]   ld_count;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int base;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] prog [0:3];

  always #5 clk = ~clk;

  imem_boot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .core_hold(core_hold), .fetch_err(fetch_err), .ld_count(ld_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Instruction memory macro: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count = wr_count + 1;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog[0] = 32'h0062E233; prog[1] = 32'hFFC4A303;
    prog[2] = 32'h0064A423; prog[3] = 32'h00B62423;
    mem_rdata = '0;
    rst = 1'b1; boot_start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    ld_last = 1'b0; fetch_req = 1'b0; fetch_addr = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_hold", core_hold, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_fetch_out", {fetch_gnt, fetch_valid, fetch_err, fetch_data}, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_mem_port", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    next_cycle();
    rst = 1'b0;

    // Boot and load 4 words
    boot_start = 1'b1;
    next_cycle();
    boot_start = 1'b0;
    chk("load_ld_ready", ld_ready, 1);
    chk("load_core_hold", core_hold, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = prog[i]; ld_last = (i == 3);
      @(negedge clk);
      chk("load_wr_en", {mem_en, mem_we}, 2'b11);
      chk("load_wr_addr", mem_addr, i);
      chk("load_wr_data", mem_wdata, prog[i]);
      next_cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("load_count4", ld_count, 4);
    chk("run_core_hold", core_hold, 0);
    chk("run_ld_ready", ld_ready, 0);
    chk("load_writes4", wr_count, 4);

    // Back-to-back fetches
    for (int k = 0; k < 4; k++) begin
      fetch_req = 1'b1; fetch_addr = 32'(4 * k);
      @(negedge clk);
      chk("fetch_gnt", fetch_gnt, 1);
      chk("fetch_rd_port", {mem_en, mem_we, mem_addr}, {2'b10, ADDR_W'(k)});
      if (k > 0) chk("fetch_data_b2b", {fetch_valid, fetch_data}, {1'b1, prog[k-1]});
      next_cycle();
    end
    fetch_req = 1'b0;
    @(negedge clk);
    chk("fetch_data_last", {fetch_valid, fetch_data}, {1'b1, prog[3]});
    next_cycle();
    chk("fetch_valid_pulse", fetch_valid, 0);

    // Misaligned then out-of-range fetch
    fetch_req = 1'b1; fetch_addr = 32'h00000002;
    @(negedge clk);
    chk("misal_gnt_noacc", {fetch_gnt, mem_en}, 2'b10);
    next_cycle();
    fetch_addr = 32'h00001000;
    @(negedge clk);
    chk("oor_gnt_noacc", {fetch_gnt, mem_en}, 2'b10);
    chk("misal_nop", {fetch_valid, fetch_data}, {1'b1, NOP});
    chk("misal_err", fetch_err, 1);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("oor_nop", {fetch_valid, fetch_data}, {1'b1, NOP});
    next_cycle();
    chk("err_sticky", {fetch_err, fetch_valid}, 2'b10);

    // boot_start with a read in flight
    fetch_req = 1'b1; fetch_addr = 32'h4;
    next_cycle();
    fetch_addr = 32'h8; boot_start = 1'b1;
    @(negedge clk);
    chk("boot_gnt_blocked", {fetch_gnt, mem_en}, 2'b00);
    chk("boot_inflight_data", {fetch_valid, fetch_data}, {1'b1, prog[1]});
    chk("boot_hold_same_cycle", core_hold, 0);
    next_cycle();
    boot_start = 1'b0; fetch_req = 1'b0;
    chk("drain_hold", {core_hold, ld_ready, fetch_valid}, 3'b100);
    chk("drain_err_clear", fetch_err, 0);
    next_cycle();
    chk("drain_to_load", {ld_ready, core_hold}, 2'b11);
    chk("drain_count_clear", ld_count, 0);

    // Full-depth download, no ld_last, with periodic gaps
    base = wr_count;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      if (i % 256 == 0) begin
        ld_valid = 1'b0;
        @(negedge clk);
        chk("gap_no_write", mem_en, 0);
        next_cycle();
      end
      if (i == (1 << ADDR_W) - 1) chk("full_hold_before_last", core_hold, 1);
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = 32'hA5A50000 ^ 32'(i);
      next_cycle();
    end
    ld_valid = 1'b0;
    chk("full_count", ld_count, 1024);
    chk("full_run", {core_hold, ld_ready}, 2'b00);
    chk("full_writes", wr_count - base, 1024);
    fetch_req = 1'b1; fetch_addr = 32'h00000FFC;
    next_cycle();
    fetch_addr = 32'h0;
    @(negedge clk);
    chk("full_word1023", {fetch_valid, fetch_data}, {1'b1, 32'hA5A503FF});
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("full_word0", {fetch_valid, fetch_data}, {1'b1, 32'hA5A50000});
    next_cycle();

    // Reset in the middle of a download
    boot_start = 1'b1;
    next_cycle();
    boot_start = 1'b0;
    chk("reboot_load", ld_ready, 1);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = 32'hDEAD0000 + 32'(i);
      next_cycle();
    end
    chk("mid_count2", ld_count, 2);
    base = wr_count;
    ld_addr = 10'd5; ld_data = 32'h12345678;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_port", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("mid_rst_ctrl", {core_hold, ld_ready, ld_count}, {2'b10, 11'd0});
    next_cycle();
    rst = 1'b0;
    repeat (3) next_cycle();
    chk("mid_rst_no_writes", wr_count - base, 0);
    chk("mid_rst_idle", {ld_ready, core_hold, mem_en}, 3'b010);
    chk("mid_rst_mem5", mem[5], 32'hA5A50005);
    ld_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
